// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the TSC multi-cycle control unit: states, ISA opcodes/funcs
// and the datapath mux selects.
package mc_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_R2 = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  // R-type arithmetic occupies funcs 0..7; anything else outside the listed specials is undefined.
  function automatic logic is_known(input logic [3:0] op, input logic [5:0] fn);
    if (op <= OP_JAL) return 1'b1;
    if (op != OP_RTYPE) return 1'b0;
    return (fn <= FN_SHR) || (fn == FN_JPR) || (fn == FN_JRL) ||
           (fn == FN_WWD) || (fn == FN_HLT);
  endfunction

endpackage

// File: rtl/mc_control_fsm_inst_counter.sv
// Retired-instruction counter; wraps silently at the top of its range.
module inst_counter #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] CNT_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_en,
  output logic [WORD_SIZE-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= CNT_INIT;
    else if (inc_en) count <= count + 1'b1;
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control for the 16-bit TSC datapath: IF/ID/EX/MEM/WB sequencing,
// memory handshake, datapath strobes, retire counting and halt.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] CNT_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func_code,
  input  logic                 bcond,
  input  logic                 mem_ack,
  output logic [3:0]           alu_op,
  output logic [5:0]           inst_func_code,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 wwd_valid,
  output logic                 is_halted,
  output logic [WORD_SIZE-1:0] num_inst
);

  state_t state, next_state;
  logic   retire;
  logic   is_rtype;

  assign is_rtype = (opcode == OP_RTYPE);

  // Strobes are pure decodes; reset gates them so nothing fires while the FSM is held.
  always_comb begin
    next_state     = state;
    retire         = 1'b0;
    alu_op         = '0;
    inst_func_code = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    i_or_d         = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = PC_SRC_INC;
    reg_write      = 1'b0;
    reg_dst        = REG_DST_RT;
    mem_to_reg     = M2R_ALU;
    wwd_valid      = 1'b0;
    if (!reset) begin
      if (is_rtype) inst_func_code = func_code;
      if (state inside {S_ID, S_EX, S_MEM, S_WB}) alu_op = opcode;
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ack) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = S_ID;
          end
        end
        S_ID: begin
          next_state = S_IF;
          if (!is_known(opcode, func_code)) begin
            retire = 1'b1;
          end else if (opcode == OP_JMP) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            retire   = 1'b1;
          end else if (opcode == OP_JAL || (is_rtype && func_code == FN_JRL)) begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_R2;
            mem_to_reg = M2R_PC;
            pc_write   = 1'b1;
            pc_src     = (opcode == OP_JAL) ? PC_SRC_JUMP : PC_SRC_REG;
            retire     = 1'b1;
          end else if (is_rtype && func_code == FN_JPR) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_REG;
            retire   = 1'b1;
          end else if (is_rtype && func_code == FN_WWD) begin
            wwd_valid = 1'b1;
            retire    = 1'b1;
          end else if (is_rtype && func_code == FN_HLT) begin
            retire     = 1'b1;
            next_state = S_HALT;
          end else begin
            next_state = S_EX;
          end
        end
        S_EX: begin
          if (opcode <= OP_BLZ) begin
            pc_write   = bcond;
            pc_src     = PC_SRC_BRANCH;
            retire     = 1'b1;
            next_state = S_IF;
          end else if (opcode == OP_LWD || opcode == OP_SWD) begin
            next_state = S_MEM;
          end else begin
            next_state = S_WB;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (opcode == OP_LWD);
          mem_write = (opcode == OP_SWD);
          if (mem_ack) begin
            if (opcode == OP_LWD) begin
              next_state = S_WB;
            end else begin
              retire     = 1'b1;
              next_state = S_IF;
            end
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype ? REG_DST_RD : REG_DST_RT;
          mem_to_reg = (opcode == OP_LWD) ? M2R_MDR : M2R_ALU;
          retire     = 1'b1;
          next_state = S_IF;
        end
        S_HALT:  next_state = S_HALT;
        default: next_state = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IF;
      is_halted <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_ID && next_state == S_HALT) is_halted <= 1'b1;
    end
  end

  inst_counter #(
    .WORD_SIZE(WORD_SIZE),
    .CNT_INIT (CNT_INIT)
  ) u_inst_counter (
    .clk   (clk),
    .reset (reset),
    .inc_en(retire),
    .count (num_inst)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboarded bench for mc_control_fsm: per-cycle expected strobe vectors are queued
// with the stimulus and compared against the sampled outputs.
module tb_mc_control_fsm;

  localparam logic [15:0] CNT_INIT = 16'hFFFE;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic        bcond;
  logic        mem_ack;
  logic [3:0]  alu_op;
  logic [5:0]  inst_func_code;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_dst, mem_to_reg;
  logic        wwd_valid, is_halted;
  logic [15:0] num_inst;

  int passed = 0;
  int checks = 0;

  logic [16:0] obs;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  mc_control_fsm #(.WORD_SIZE(16), .CNT_INIT(CNT_INIT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
    .bcond(bcond), .mem_ack(mem_ack), .alu_op(alu_op),
    .inst_func_code(inst_func_code), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .wwd_valid(wwd_valid), .is_halted(is_halted), .num_inst(num_inst)
  );

  assign obs = {alu_op, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
                reg_write, reg_dst, mem_to_reg, wwd_valid};

  function automatic logic [16:0] mk(input logic [3:0] a, input logic mr, input logic mw,
                                     input logic iod, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] m2r,
                                     input logic wwd);
    return {a, mr, mw, iod, irw, pcw, pcs, rw, rd, m2r, wwd};
  endfunction

  localparam logic [16:0] IF_ACK  = 17'h01300;
  localparam logic [16:0] IF_WAIT = 17'h01000;

  // Drives one cycle starting at posedge+1; queues the expectation and the negedge sample.
  task automatic applyStimulus(input string nm, input logic [3:0] op, input logic [5:0] fn,
                               input logic bc, input logic ack, input logic [16:0] e);
    opcode = op; func_code = fn; bcond = bc; mem_ack = ack;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    got_q.push_back(obs);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 4'd15; func_code = 6'd28; bcond = 1'b1; mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 17'h0) $display("[TB] FAIL reset_strobes got %h expected %h", obs, 17'h0);
    else passed++;
    checks++;
    if (num_inst !== CNT_INIT) $display("[TB] FAIL reset_num_inst got %h expected %h", num_inst, CNT_INIT);
    else passed++;
    checks++;
    if (is_halted !== 1'b0) $display("[TB] FAIL reset_halt got %b expected 0", is_halted);
    else passed++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_adi();
    applyStimulus("adi_if",  4'd4, 6'd5, 1'b0, 1'b1, IF_ACK);
    applyStimulus("adi_id",  4'd4, 6'd5, 1'b0, 1'b1, mk(4, 0,0,0,0,0, 0, 0, 0, 0, 0));
    checks++;
    if (inst_func_code !== 6'd0) $display("[TB] FAIL adi_func got %h expected 0", inst_func_code);
    else passed++;
    applyStimulus("adi_ex",  4'd4, 6'd5, 1'b1, 1'b1, mk(4, 0,0,0,0,0, 0, 0, 0, 0, 0));
    applyStimulus("adi_wb",  4'd4, 6'd5, 1'b0, 1'b1, mk(4, 0,0,0,0,0, 0, 1, 0, 0, 0));
    applyStimulus("adi_end", 4'd4, 6'd5, 1'b0, 1'b0, IF_WAIT);
    while (exp_q.size() > 0) begin
      logic [16:0] e, g; string nm;
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL %s got %h expected %h", nm, g, e);
      else passed++;
    end
    checks++;
    if (num_inst !== CNT_INIT + 16'd1) $display("[TB] FAIL adi_count got %h expected %h", num_inst, CNT_INIT + 16'd1);
    else passed++;
  endtask

  task automatic test_lwd();
    applyStimulus("lwd_if", 4'd7, 6'd0, 1'b0, 1'b1, IF_ACK);
    applyStimulus("lwd_id", 4'd7, 6'd0, 1'b0, 1'b0, mk(7, 0,0,0,0,0, 0, 0, 0, 0, 0));
    applyStimulus("lwd_ex", 4'd7, 6'd0, 1'b0, 1'b0, mk(7, 0,0,0,0,0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus("lwd_mem_wait", 4'd7, 6'd0, 1'b0, 1'b0, mk(7, 1,0,1,0,0, 0, 0, 0, 0, 0));
    applyStimulus("lwd_mem_ack", 4'd7, 6'd0, 1'b0, 1'b1, mk(7, 1,0,1,0,0, 0, 0, 0, 0, 0));
    applyStimulus("lwd_wb",  4'd7, 6'd0, 1'b0, 1'b0, mk(7, 0,0,0,0,0, 0, 1, 0, 1, 0));
    applyStimulus("lwd_end", 4'd7, 6'd0, 1'b0, 1'b0, IF_WAIT);
    while (exp_q.size() > 0) begin
      logic [16:0] e, g; string nm;
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL %s got %h expected %h", nm, g, e);
      else passed++;
    end
    checks++;
    if (num_inst !== 16'h0000) $display("[TB] FAIL lwd_count_wrap got %h expected 0000", num_inst);
    else passed++;
  endtask

  task automatic test_branch();
    applyStimulus("bne0_if", 4'd0, 6'd3, 1'b1, 1'b1, IF_ACK);
    applyStimulus("bne0_id", 4'd0, 6'd3, 1'b1, 1'b0, mk(0, 0,0,0,0,0, 0, 0, 0, 0, 0));
    applyStimulus("bne0_ex", 4'd0, 6'd3, 1'b0, 1'b0, mk(0, 0,0,0,0,0, 1, 0, 0, 0, 0));
    applyStimulus("bne1_if", 4'd0, 6'd3, 1'b0, 1'b1, IF_ACK);
    applyStimulus("bne1_id", 4'd0, 6'd3, 1'b0, 1'b0, mk(0, 0,0,0,0,0, 0, 0, 0, 0, 0));
    applyStimulus("bne1_ex", 4'd0, 6'd3, 1'b1, 1'b0, mk(0, 0,0,0,0,1, 1, 0, 0, 0, 0));
    applyStimulus("bne_end", 4'd0, 6'd3, 1'b0, 1'b0, IF_WAIT);
    while (exp_q.size() > 0) begin
      logic [16:0] e, g; string nm;
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL %s got %h expected %h", nm, g, e);
      else passed++;
    end
    checks++;
    if (num_inst !== 16'h0002) $display("[TB] FAIL bne_count got %h expected 0002", num_inst);
    else passed++;
  endtask

  task automatic test_jal();
    applyStimulus("jal_if",  4'd10, 6'd0, 1'b0, 1'b1, IF_ACK);
    applyStimulus("jal_id",  4'd10, 6'd0, 1'b0, 1'b1, mk(10, 0,0,0,0,1, 2, 1, 2, 2, 0));
    applyStimulus("jal_end", 4'd10, 6'd0, 1'b0, 1'b0, IF_WAIT);
    while (exp_q.size() > 0) begin
      logic [16:0] e, g; string nm;
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL %s got %h expected %h", nm, g, e);
      else passed++;
    end
    checks++;
    if (num_inst !== 16'h0003) $display("[TB] FAIL jal_count got %h expected 0003", num_inst);
    else passed++;
  endtask

  task automatic test_rtype();
    applyStimulus("orr_if", 4'd15, 6'd3, 1'b0, 1'b1, IF_ACK);
    applyStimulus("orr_id", 4'd15, 6'd3, 1'b0, 1'b0, mk(15, 0,0,0,0,0, 0, 0, 0, 0, 0));
    checks++;
    if (inst_func_code !== 6'd3) $display("[TB] FAIL orr_func got %h expected 03", inst_func_code);
    else passed++;
    applyStimulus("orr_ex", 4'd15, 6'd3, 1'b0, 1'b0, mk(15, 0,0,0,0,0, 0, 0, 0, 0, 0));
    applyStimulus("orr_wb", 4'd15, 6'd3, 1'b0, 1'b0, mk(15, 0,0,0,0,0, 0, 1, 1, 0, 0));
    applyStimulus("jpr_if", 4'd15, 6'd25, 1'b0, 1'b1, IF_ACK);
    applyStimulus("jpr_id", 4'd15, 6'd25, 1'b0, 1'b0, mk(15, 0,0,0,0,1, 3, 0, 0, 0, 0));
    applyStimulus("unk_if", 4'd12, 6'd0, 1'b0, 1'b1, IF_ACK);
    applyStimulus("unk_id", 4'd12, 6'd0, 1'b0, 1'b0, mk(12, 0,0,0,0,0, 0, 0, 0, 0, 0));
    applyStimulus("rt_end", 4'd12, 6'd0, 1'b0, 1'b0, IF_WAIT);
    while (exp_q.size() > 0) begin
      logic [16:0] e, g; string nm;
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL %s got %h expected %h", nm, g, e);
      else passed++;
    end
    checks++;
    if (num_inst !== 16'h0006) $display("[TB] FAIL rtype_count got %h expected 0006", num_inst);
    else passed++;
  endtask

  task automatic test_swd_reset();
    applyStimulus("swd_if",  4'd8, 6'd0, 1'b0, 1'b1, IF_ACK);
    applyStimulus("swd_id",  4'd8, 6'd0, 1'b0, 1'b0, mk(8, 0,0,0,0,0, 0, 0, 0, 0, 0));
    applyStimulus("swd_ex",  4'd8, 6'd0, 1'b0, 1'b0, mk(8, 0,0,0,0,0, 0, 0, 0, 0, 0));
    applyStimulus("swd_mem", 4'd8, 6'd0, 1'b0, 1'b0, mk(8, 0,1,1,0,0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      logic [16:0] e, g; string nm;
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL %s got %h expected %h", nm, g, e);
      else passed++;
    end
    checks++;
    if (mem_write !== 1'b1) $display("[TB] FAIL swd_mem_hold got %b expected 1", mem_write);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 17'h0) $display("[TB] FAIL swd_reset_strobes got %h expected %h", obs, 17'h0);
    else passed++;
    checks++;
    if (num_inst !== CNT_INIT) $display("[TB] FAIL swd_reset_count got %h expected %h", num_inst, CNT_INIT);
    else passed++;
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus("swd_after", 4'd8, 6'd0, 1'b0, 1'b0, IF_WAIT);
    while (exp_q.size() > 0) begin
      logic [16:0] e, g; string nm;
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL %s got %h expected %h", nm, g, e);
      else passed++;
    end
  endtask

  task automatic test_wwd_hlt();
    applyStimulus("wwd_if", 4'd15, 6'd28, 1'b0, 1'b1, IF_ACK);
    applyStimulus("wwd_id", 4'd15, 6'd28, 1'b0, 1'b0, mk(15, 0,0,0,0,0, 0, 0, 0, 0, 1));
    applyStimulus("hlt_if", 4'd15, 6'd29, 1'b0, 1'b1, IF_ACK);
    applyStimulus("hlt_id", 4'd15, 6'd29, 1'b0, 1'b0, mk(15, 0,0,0,0,0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      applyStimulus("halt_quiet", 4'd15, 6'd29, 1'($urandom_range(1)), 1'($urandom_range(1)), 17'h0);
      checks++;
      if (is_halted !== 1'b1) $display("[TB] FAIL halt_sticky cycle %0d got %b expected 1", i, is_halted);
      else passed++;
    end
    while (exp_q.size() > 0) begin
      logic [16:0] e, g; string nm;
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL %s got %h expected %h", nm, g, e);
      else passed++;
    end
    checks++;
    if (num_inst !== CNT_INIT + 16'd2) $display("[TB] FAIL hlt_count got %h expected %h", num_inst, CNT_INIT + 16'd2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_adi();
    test_lwd();
    test_branch();
    test_jal();
    test_rtype();
    test_swd_reset();
    test_wwd_hlt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main control unit for the 16-bit TSC datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with memory.
- Drives the 4-bit ALU-op and the 6-bit function code into the ALU control block, plus all datapath strobes.
- Counts retired instructions and reports halt.

Parameters:
- WORD_SIZE, 16, data/address width; sets the width of num_inst.
- CNT_INIT, 0, value loaded into num_inst on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  4  IR[15:12], stable from the cycle after ir_write.
- func_code  in  6  IR[5:0].
- bcond  in  1  branch condition from ALU, valid in S_EX.
- mem_ack  in  1  memory completes the current read or write this cycle.
- alu_op  out  4  equals opcode in S_ID, S_EX, S_MEM and S_WB; 0 otherwise.
- inst_func_code  out  6  equals func_code when opcode==15; otherwise 0.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- i_or_d  out  1  address mux select: 0 = PC, 1 = ALU result.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  PC load enable.
- pc_src  out  2  PC source: 0 = PC+1, 1 = PC+1+imm, 2 = {PC[15:12], target12}, 3 = rs.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  destination select: 0 = rt, 1 = rd, 2 = $2.
- mem_to_reg  out  2  write-data select: 0 = ALU, 1 = MDR, 2 = PC.
- wwd_valid  out  1  one-cycle pulse; output port captures rs.
- is_halted  out  1  sticky halt flag.
- num_inst  out  WORD_SIZE  count of retired instructions.

Behaviour:
- States: S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT.
- State, is_halted and num_inst are registered. All strobes are combinational decodes of state, opcode, func_code, bcond and mem_ack.
- Reset: while reset is high, state=S_IF, num_inst=CNT_INIT, is_halted=0, and every strobe is forced to 0.
- Reset asserted mid-instruction abandons the instruction with no retire and no write.
- S_IF: mem_read=1, i_or_d=0.
  - Stay in S_IF while mem_ack=0.
  - On mem_ack: ir_write=1, pc_write=1, pc_src=0, go to S_ID.
- S_ID:
  - HLT (15/29): go to S_HALT.
  - JMP (9): pc_write, pc_src=2, retire, go to S_IF.
  - JAL (10): reg_write, reg_dst=2, mem_to_reg=2, pc_write, pc_src=2, retire, go to S_IF.
  - JPR (15/25): pc_write, pc_src=3, retire, go to S_IF.
  - JRL (15/26): same as JPR, plus the JAL register write.
  - WWD (15/28): wwd_valid=1, retire, go to S_IF.
  - Unknown opcode or func: retire as a no-op, go to S_IF.
  - All others: go to S_EX.
- S_EX:
  - Branches (opcodes 0-3): pc_write=bcond, pc_src=1, retire, go to S_IF.
  - LWD (7) and SWD (8): go to S_MEM.
  - R-type arithmetic, ADI, ORI and LHI: go to S_WB.
- S_MEM: i_or_d=1; mem_read=1 for LWD, mem_write=1 for SWD.
  - Stay in S_MEM while mem_ack=0.
  - On ack, LWD goes to S_WB.
  - On ack, SWD retires and goes to S_IF.
- S_WB: reg_write=1.
  - reg_dst=1 for R-type; otherwise 0.
  - mem_to_reg=1 for LWD; otherwise 0.
  - Retire, go to S_IF.
- S_HALT: terminal until reset.
  - is_halted=1 from the cycle after HLT is in S_ID.
  - HLT itself counts as retired.
  - All strobes are 0.
- Retire increments num_inst by 1 at the clock edge leaving the final state.
  - num_inst wraps from 16'hFFFF to 0 with no flag.
- Strobes are never asserted together: mem_read and mem_write are never both 1; ir_write only occurs in S_IF.
- A mem_ack outside S_IF or S_MEM is ignored.

Decomposition:
- Shared package/include (opcodes.v) holds:
  - opcode and func constants;
  - state encodings S_IF through S_HALT;
  - pc_src, reg_dst and mem_to_reg encodings.
- One natural sub-module, inst_counter: WORD_SIZE-wide retire counter with async reset and an increment-enable input.

Test Plan:
- ADI $1,$0,5 with mem_ack immediate:
  - visits IF, ID, EX, WB (4 cycles);
  - alu_op=4 in EX; reg_write=1, reg_dst=0 in WB;
  - num_inst 0 -> 1.
- LWD with mem_ack delayed 3 cycles in S_MEM:
  - mem_read and i_or_d=1 held for 4 cycles;
  - WB asserts mem_to_reg=1;
  - 8 cycles total.
- BNE with bcond=0, then BNE with bcond=1:
  - first case: pc_write stays 0 in EX;
  - second case: pc_write=1, pc_src=1;
  - each takes 3 cycles.
- JAL:
  - S_ID shows reg_dst=2, mem_to_reg=2, pc_src=2, pc_write=1;
  - next state is S_IF.
- WWD then HLT:
  - wwd_valid is a single-cycle pulse;
  - is_halted=1 afterwards and stays 1 for 20 cycles;
  - num_inst=2; no strobes asserted.
- Reset asserted in S_MEM of SWD:
  - mem_write drops in the same cycle;
  - state returns to S_IF, num_inst=0.
